// File: rtl/uart_move_link.sv
// Move-message transceiver between the game logic and the uart core.
// TX: change detect + heartbeat into a small FIFO, paced into the uart write port. RX: paced pops into registered opponent fields.
module uart_move_link #(
  parameter int FIFO_DEPTH       = 4,
  parameter int HEARTBEAT_CYCLES = 10_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       next_turn,
  input  logic [5:0] figure_position,
  input  logic       pick_place,
  output logic [7:0] w_data,
  output logic       wr_uart,
  input  logic       tx_full,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       rx_empty,
  output logic       begin_turn,
  output logic [5:0] oponent_position,
  output logic       oponent_pick,
  output logic       rx_strobe,
  output logic       tx_overflow
);

  localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int HB_W = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
  localparam logic [HB_W-1:0] HB_LAST = HB_W'((HEARTBEAT_CYCLES > 0) ? HEARTBEAT_CYCLES - 1 : 0);
  localparam logic HB_EN = (HEARTBEAT_CYCLES != 0);
  localparam logic [AW:0] FIFO_FULL_CNT = (AW + 1)'(FIFO_DEPTH);

  localparam logic [0:0] T_IDLE = 1'b0;
  localparam logic [0:0] T_GAP  = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_GAP  = 1'b1;

  logic [7:0]      cur;
  logic [7:0]      prev;
  logic            change;
  logic            hb_expire;
  logic            push_req;
  logic            push_ok;
  logic            pop;
  logic            fifo_empty;
  logic            fifo_full;
  logic            link_idle;
  logic [7:0]      push_word;
  logic [HB_W-1:0] hb_cnt;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [0:0]      tx_state;
  logic [0:0]      rx_state;

  always_comb begin
    cur        = {next_turn, figure_position, pick_place};
    change     = (cur != prev);
    hb_expire  = HB_EN && (hb_cnt == HB_LAST);
    push_req   = change || hb_expire;
    // A same-cycle change wins over the heartbeat and carries the fresh word.
    push_word  = change ? cur : prev;
    fifo_empty = (count == '0);
    fifo_full  = (count == FIFO_FULL_CNT);
    link_idle  = fifo_empty && (tx_state == T_IDLE);
    pop        = (tx_state == T_IDLE) && !fifo_empty && !tx_full;
    push_ok    = push_req && (!fifo_full || pop);
  end

  // The heartbeat interval only runs while nothing is queued or in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev        <= 8'h00;
      hb_cnt      <= '0;
      tx_overflow <= 1'b0;
    end else begin
      prev <= cur;
      if (push_req) begin
        hb_cnt <= '0;
      end else if (HB_EN && link_idle) begin
        hb_cnt <= hb_cnt + HB_W'(1);
      end else begin
        hb_cnt <= hb_cnt;
      end
      if (push_req && !push_ok) begin
        tx_overflow <= 1'b1;
      end else begin
        tx_overflow <= tx_overflow;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_word;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // TX pacing: every write strobe is followed by at least one idle cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tx_state <= T_IDLE;
      w_data   <= 8'h00;
      wr_uart  <= 1'b0;
    end else begin
      case (tx_state)
        T_IDLE: begin
          if (pop) begin
            w_data   <= mem[rd_ptr];
            wr_uart  <= 1'b1;
            tx_state <= T_GAP;
          end else begin
            wr_uart  <= 1'b0;
          end
        end
        T_GAP: begin
          wr_uart  <= 1'b0;
          tx_state <= T_IDLE;
        end
        default: begin
          wr_uart  <= 1'b0;
          tx_state <= T_IDLE;
        end
      endcase
    end
  end

  // RX pacing: the gap cycle lets the uart FIFO advance before the next look.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state         <= R_IDLE;
      rd_uart          <= 1'b0;
      rx_strobe        <= 1'b0;
      begin_turn       <= 1'b0;
      oponent_position <= 6'd0;
      oponent_pick     <= 1'b0;
    end else begin
      case (rx_state)
        R_IDLE: begin
          if (!rx_empty) begin
            rd_uart   <= 1'b1;
            rx_strobe <= 1'b1;
            {begin_turn, oponent_position, oponent_pick} <= r_data;
            rx_state  <= R_GAP;
          end else begin
            rd_uart   <= 1'b0;
            rx_strobe <= 1'b0;
          end
        end
        R_GAP: begin
          rd_uart   <= 1'b0;
          rx_strobe <= 1'b0;
          rx_state  <= R_IDLE;
        end
        default: begin
          rd_uart   <= 1'b0;
          rx_strobe <= 1'b0;
          rx_state  <= R_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_move_link.sv
// Directed bench for uart_move_link: one instance without heartbeat, one with a 16-cycle heartbeat.
module tb_uart_move_link;

  logic       clk = 1'b0;
  logic       rst;
  logic       next_turn;
  logic [5:0] figure_position;
  logic       pick_place;
  logic       tx_full;
  logic [7:0] r_data;
  logic       rx_empty;

  logic [7:0] w_a, w_b;
  logic       wr_a, wr_b, rd_a, rd_b, bt_a, bt_b, pk_a, pk_b, rs_a, rs_b, ov_a, ov_b;
  logic [5:0] op_a, op_b;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int wr_err   = 0;
  logic wr_a_prev = 1'b0;
  int qa_cyc[$];
  logic [7:0] qa_dat[$];
  int qb_cyc[$];
  logic [7:0] qb_dat[$];
  int rd_cyc[$];
  int c0, c1, c2;

  uart_move_link #(.FIFO_DEPTH(4), .HEARTBEAT_CYCLES(0)) dut_a (
    .clk(clk), .rst(rst), .next_turn(next_turn), .figure_position(figure_position),
    .pick_place(pick_place), .w_data(w_a), .wr_uart(wr_a), .tx_full(tx_full),
    .r_data(r_data), .rd_uart(rd_a), .rx_empty(rx_empty), .begin_turn(bt_a),
    .oponent_position(op_a), .oponent_pick(pk_a), .rx_strobe(rs_a), .tx_overflow(ov_a)
  );

  uart_move_link #(.FIFO_DEPTH(4), .HEARTBEAT_CYCLES(16)) dut_b (
    .clk(clk), .rst(rst), .next_turn(next_turn), .figure_position(figure_position),
    .pick_place(pick_place), .w_data(w_b), .wr_uart(wr_b), .tx_full(tx_full),
    .r_data(r_data), .rd_uart(rd_b), .rx_empty(rx_empty), .begin_turn(bt_b),
    .oponent_position(op_b), .oponent_pick(pk_b), .rx_strobe(rs_b), .tx_overflow(ov_b)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_a) begin qa_cyc.push_back(cyc); qa_dat.push_back(w_a); end
    if (wr_b) begin qb_cyc.push_back(cyc); qb_dat.push_back(w_b); end
    if (rd_a) rd_cyc.push_back(cyc);
    if (wr_a && wr_a_prev) wr_err++;
    wr_a_prev = wr_a;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic set_word(input logic [7:0] w);
    next_turn       = w[7];
    figure_position = w[6:1];
    pick_place      = w[0];
  endtask

  task automatic clear_logs();
    qa_cyc.delete(); qa_dat.delete();
    qb_cyc.delete(); qb_dat.delete();
    rd_cyc.delete();
  endtask

  initial begin
    rst = 1'b1; tx_full = 1'b0; rx_empty = 1'b1; r_data = 8'h00;
    set_word(8'h00);
    step(3);
    check_eq("reset_w_data", {24'd0, w_a}, 32'h0);
    check_eq("reset_strobes", {28'd0, wr_a, rd_a, rs_a, ov_a}, 32'h0);
    check_eq("reset_rx_fields", {24'd0, bt_a, op_a, pk_a}, 32'h0);
    rst = 1'b0;
    step(1);

    // Single move: 0x99 goes out once, two cycles after the input change.
    clear_logs();
    c0 = cyc;
    set_word(8'h99);
    step(40);
    check_eq("single_count", qa_cyc.size(), 32'd1);
    check_eq("single_data", {24'd0, qa_dat[0]}, 32'h99);
    check_eq("single_latency", qa_cyc[0] - c0, 32'd2);
    check_eq("hb_count", qb_cyc.size(), 32'd3);
    check_eq("hb_first", qb_cyc[0] - c0, 32'd2);
    check_eq("hb_period1", qb_cyc[1] - qb_cyc[0], 32'd18);
    check_eq("hb_period2", qb_cyc[2] - qb_cyc[1], 32'd18);
    check_eq("hb_data", {24'd0, qb_dat[2]}, 32'h99);

    // Change mid-interval restarts the heartbeat from the new push.
    clear_logs();
    c1 = cyc;
    set_word(8'h0A);
    step(25);
    check_eq("chg_a_count", qa_cyc.size(), 32'd1);
    check_eq("chg_a_data", {24'd0, qa_dat[0]}, 32'h0A);
    check_eq("chg_b_count", qb_cyc.size(), 32'd2);
    check_eq("chg_b_first", qb_cyc[0] - c1, 32'd2);
    check_eq("chg_b_restart", qb_cyc[1] - c1, 32'd20);
    check_eq("chg_b_data", {24'd0, qb_dat[1]}, 32'h0A);

    // Overflow: five words into a depth-4 queue while the uart is full.
    tx_full = 1'b1;
    clear_logs();
    for (int i = 1; i <= 5; i++) begin
      set_word(8'(i * 17));
      step(1);
      check_eq($sformatf("ovf_after_%0d", i), {31'd0, ov_a}, (i == 5) ? 32'd1 : 32'd0);
    end
    step(3);
    check_eq("ovf_no_write_while_full", qa_cyc.size(), 32'd0);
    c2 = cyc;
    tx_full = 1'b0;
    step(12);
    check_eq("drain_count", qa_cyc.size(), 32'd4);
    for (int i = 0; i < 4; i++)
      check_eq($sformatf("drain_data_%0d", i), {24'd0, qa_dat[i]}, 32'(8'((i + 1) * 17)));
    check_eq("drain_first_latency", qa_cyc[0] - c2, 32'd1);
    for (int i = 1; i < 4; i++)
      check_eq($sformatf("drain_gap_%0d", i), {31'd0, (qa_cyc[i] - qa_cyc[i-1]) >= 2}, 32'd1);
    check_eq("ovf_sticky", {31'd0, ov_a}, 32'd1);

    // RX: one byte 0xA5.
    clear_logs();
    r_data = 8'hA5; rx_empty = 1'b0;
    step(1);
    check_eq("rx1_rd", {30'd0, rd_a, rs_a}, 32'h3);
    check_eq("rx1_fields", {24'd0, bt_a, op_a, pk_a}, {24'd0, 1'b1, 6'd18, 1'b1});
    rx_empty = 1'b1;
    step(1);
    check_eq("rx1_pulse_end", {30'd0, rd_a, rs_a}, 32'h0);
    step(4);
    check_eq("rx1_pop_count", rd_cyc.size(), 32'd1);
    check_eq("rx1_hold", {24'd0, bt_a, op_a, pk_a}, 32'hA5);

    // RX: two bytes queued, 0x3C then 0xC3.
    clear_logs();
    r_data = 8'h3C; rx_empty = 1'b0;
    step(1);
    check_eq("rx2_first", {24'd0, bt_a, op_a, pk_a}, {24'd0, 1'b0, 6'd30, 1'b0});
    r_data = 8'hC3;
    step(2);
    check_eq("rx2_second", {24'd0, bt_a, op_a, pk_a}, {24'd0, 1'b1, 6'd33, 1'b1});
    rx_empty = 1'b1;
    step(4);
    check_eq("rx2_pop_count", rd_cyc.size(), 32'd2);
    check_eq("rx2_spacing", rd_cyc[1] - rd_cyc[0], 32'd2);
    check_eq("rx2_hold", {24'd0, bt_a, op_a, pk_a}, 32'hC3);

    // Asynchronous reset in the middle of draining three queued words.
    tx_full = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_word(8'h61 + 8'(i));
      step(1);
    end
    tx_full = 1'b0;
    step(1);
    check_eq("rst_drain_started", {31'd0, wr_a}, 32'd1);
    #2;
    rst = 1'b1;
    set_word(8'h00);
    #1;
    check_eq("rst_async_tx", {22'd0, w_a, wr_a, ov_a}, 32'h0);
    check_eq("rst_async_rx", {22'd0, bt_a, op_a, pk_a, rd_a, rs_a}, 32'h0);
    step(2);
    rst = 1'b0;
    clear_logs();
    step(20);
    check_eq("rst_no_write", qa_cyc.size(), 32'd0);
    check_eq("rst_ovf_cleared", {31'd0, ov_a}, 32'd0);
    set_word(8'h7E);
    step(4);
    check_eq("post_rst_count", qa_cyc.size(), 32'd1);
    check_eq("post_rst_data", {24'd0, qa_dat[0]}, 32'h7E);
    check_eq("wr_pulse_width", wr_err, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
